datapath_seq: RTL and testbench

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_seq_pkg.sv | 67 ++++++
 rtl/datapath_seq_seq_mem.sv | 25 ++
 rtl/datapath_seq.sv | 162 ++++++++++++++++
 tb/tb_datapath_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_seq_pkg.sv
// Shared definitions for the microcoded datapath sequencer: microword layout,
// FSM state encoding, b-operand select codes and the shared ALU opcode set.
package datapath_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_N  = 16;
    localparam int DEF_RW     = $clog2(DEF_REG_N);

    // Microword layout, LSB first: chk, flag_en, opcode, b_sel, imm, b, a, dest, wr, halt
    localparam int CHK_OFF     = 0;
    localparam int FLAG_EN_OFF = 1;
    localparam int OPCODE_OFF  = 2;
    localparam int OPCODE_W    = 4;
    localparam int B_SEL_OFF   = 6;
    localparam int B_SEL_W     = 2;
    localparam int IMM_OFF     = 8;

    function automatic int b_off(input int data_w);
        return IMM_OFF + data_w;
    endfunction

    function automatic int a_off(input int data_w, input int rw);
        return b_off(data_w) + rw;
    endfunction

    function automatic int dest_off(input int data_w, input int rw);
        return a_off(data_w, rw) + rw;
    endfunction

    function automatic int wr_off(input int data_w, input int rw);
        return dest_off(data_w, rw) + rw;
    endfunction

    function automatic int halt_off(input int data_w, input int rw);
        return wr_off(data_w, rw) + 1;
    endfunction

    function automatic int uw_calc(input int data_w, input int rw);
        return halt_off(data_w, rw) + 1;
    endfunction

    localparam int UW = uw_calc(DEF_DATA_W, DEF_RW);

    localparam logic [B_SEL_W-1:0] BSEL_REG   = 2'd0;
    localparam logic [B_SEL_W-1:0] BSEL_IMM   = 2'd1;
    localparam logic [B_SEL_W-1:0] BSEL_FLAGS = 2'd2;

    // Shared ALU opcode set used by the datapath that consumes our opcode output
    typedef enum logic [OPCODE_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SHL    = 4'd5,
        ALU_SHR    = 4'd6,
        ALU_PASS_B = 4'd7
    } alu_op_e;

endpackage

// File: rtl/datapath_seq_seq_mem.sv
// Microword store: one synchronous write port, one synchronous read port.
// Deliberately not reset so a program survives a sequencer reset.
module seq_mem #(
    parameter int DEPTH = 32,
    parameter int UW    = 38,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [UW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [UW-1:0] rd_data
);

    logic [UW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/datapath_seq.sv
// Microcoded datapath sequencer: steps through program slots, decoding each into
// register/ALU control. Optional result checker enabled by DATAPATH_SEQ_CHECK_EN.
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 16,
    parameter int REG_N  = 16,
    localparam int RW    = $clog2(REG_N),
    localparam int AW    = $clog2(DEPTH),
    localparam int MUW   = uw_calc(DATA_W, RW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step_en,
    input  logic                loop_mode,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [MUW-1:0]      prog_data,
    input  logic [DATA_W-1:0]   result,
    output logic [REG_N-1:0]    reg_en,
    output logic [RW-1:0]       reg_a,
    output logic [RW-1:0]       reg_b,
    output logic [DATA_W-1:0]   imm,
    output logic [B_SEL_W-1:0]  b_sel,
    output logic [OPCODE_W-1:0] opcode,
    output logic                flag_en,
    output logic                busy,
    output logic                done,
`ifdef DATAPATH_SEQ_CHECK_EN
    output logic                mismatch,
    output logic [7:0]          err_count,
`endif
    output logic [AW-1:0]       pc
);

    localparam int B_OFF    = b_off(DATA_W);
    localparam int A_OFF    = a_off(DATA_W, RW);
    localparam int DEST_OFF = dest_off(DATA_W, RW);
    localparam int WR_OFF   = wr_off(DATA_W, RW);
    localparam int HALT_OFF = halt_off(DATA_W, RW);
    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    state_e         state, state_n;
    logic [AW-1:0]  pc_n;
    logic [MUW-1:0] word;
    logic           w_halt;
    logic           w_wr;
    logic [RW-1:0]  w_dest;
    logic           run_step;
    logic           start_ok;
    logic           mem_we;

    assign w_halt   = word[HALT_OFF];
    assign w_wr     = word[WR_OFF];
    assign w_dest   = word[DEST_OFF +: RW];
    assign busy     = (state == ST_PRIME) || (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign run_step = (state == ST_RUN) && step_en;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mem_we   = prog_we && !busy;

    // Read address is the next pc so the following slot is ready without a bubble
    seq_mem #(
        .DEPTH (DEPTH),
        .UW    (MUW)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc_n),
        .rd_data (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_PRIME;
                    pc_n    = '0;
                end
            end
            // Re-reads slot 0 so a program write in the start cycle is observed
            ST_PRIME: state_n = ST_RUN;
            ST_RUN: begin
                if (step_en) begin
                    if (w_halt) begin
                        state_n = ST_DONE;
                    end else if (pc == LAST_PC) begin
                        if (loop_mode) begin
                            pc_n = '0;
                        end else begin
                            state_n = ST_DONE;
                        end
                    end else begin
                        pc_n = pc + AW'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_en  = '0;
        reg_a   = '0;
        reg_b   = '0;
        imm     = '0;
        b_sel   = '0;
        opcode  = '0;
        flag_en = 1'b0;
        if (state == ST_RUN) begin
            if (w_wr) begin
                reg_en = {{(REG_N-1){1'b0}}, 1'b1} << w_dest;
            end
            reg_a   = word[A_OFF +: RW];
            reg_b   = word[B_OFF +: RW];
            imm     = word[IMM_OFF +: DATA_W];
            b_sel   = word[B_SEL_OFF +: B_SEL_W];
            opcode  = word[OPCODE_OFF +: OPCODE_W];
            flag_en = word[FLAG_EN_OFF];
        end
    end

`ifdef DATAPATH_SEQ_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            mismatch <= 1'b0;
            if (start_ok) begin
                err_count <= '0;
            end else if (run_step && word[CHK_OFF] &&
                         (result != word[IMM_OFF +: DATA_W])) begin
                mismatch <= 1'b1;
                if (err_count != 8'hff) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{result, word[CHK_OFF], run_step, start_ok};
`endif

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq at DEPTH=4; the checker scenario is compiled
// in only when DATAPATH_SEQ_CHECK_EN is defined.
module tb_datapath_seq;
    import datapath_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, step_en, loop_mode, prog_we;
    logic [1:0]  prog_addr;
    logic [37:0] prog_data;
    logic [15:0] result;
    logic [15:0] reg_en;
    logic [3:0]  reg_a, reg_b;
    logic [15:0] imm;
    logic [1:0]  b_sel;
    logic [3:0]  opcode;
    logic        flag_en, busy, done;
    logic [1:0]  pc;
`ifdef DATAPATH_SEQ_CHECK_EN
    logic        mismatch;
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    datapath_seq #(.DEPTH(4), .DATA_W(16), .REG_N(16)) dut (
        .clk(clk), .rst(rst), .start(start), .step_en(step_en),
        .loop_mode(loop_mode), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .result(result), .reg_en(reg_en),
        .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .b_sel(b_sel),
        .opcode(opcode), .flag_en(flag_en), .busy(busy), .done(done),
`ifdef DATAPATH_SEQ_CHECK_EN
        .mismatch(mismatch), .err_count(err_count),
`endif
        .pc(pc)
    );

    function automatic logic [37:0] mw(input logic halt, input logic wr,
                                       input logic [3:0] dest, input logic [3:0] a,
                                       input logic [3:0] b, input logic [15:0] im,
                                       input logic [1:0] bs, input logic [3:0] op,
                                       input logic fl, input logic ck);
        return {halt, wr, dest, a, b, im, bs, op, fl, ck};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [37:0] w);
        prog_addr = 2'(addr);
        prog_data = w;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; step_en = 0; loop_mode = 0; prog_we = 0;
        prog_addr = 0; prog_data = 0; result = 0;
        tick(); tick();
        n_checks++;
        if ({busy, done, pc} !== 4'b0) begin
            n_fail++; $display("FAIL reset_status: got busy=%b done=%b pc=%0d, want 0 0 0", busy, done, pc);
        end
        n_checks++;
        if ({reg_en, reg_a, reg_b, imm, b_sel, opcode, flag_en} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got reg_en=%h imm=%h opcode=%h, want all zero", reg_en, imm, opcode);
        end
        rst = 1'b0;
        tick();
    endtask

    // Three-slot program; slot 0 is rewritten in the same cycle as start
    task automatic test_basic();
        load(0, mw(0, 1, 9, 0, 0, 16'h1234, 0, 0, 0, 0));
        load(1, mw(0, 1, 2, 0, 0, 16'hffff, 1, 0, 0, 0));
        load(2, mw(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
        load(3, mw(0, 1, 3, 0, 0, 16'h0333, 1, 0, 0, 0));
        step_en = 1; loop_mode = 0;
        prog_addr = 0; prog_data = mw(0, 1, 1, 0, 0, 16'h7fff, 1, 0, 0, 0);
        prog_we = 1; start = 1;
        tick();
        prog_we = 0; start = 0;
        n_checks++;
        if (!(busy === 1 && done === 0 && reg_en === 16'h0 && pc === 2'd0)) begin
            n_fail++; $display("FAIL prime: got busy=%b done=%b reg_en=%h pc=%0d, want 1 0 0000 0", busy, done, reg_en, pc);
        end
        tick();
        n_checks++;
        if (!(reg_en === 16'h0002 && imm === 16'h7fff && b_sel === 2'd1 && pc === 2'd0)) begin
            n_fail++; $display("FAIL slot0: got reg_en=%h imm=%h b_sel=%0d pc=%0d, want 0002 7fff 1 0", reg_en, imm, b_sel, pc);
        end
        tick();
        n_checks++;
        if (!(reg_en === 16'h0004 && imm === 16'hffff && pc === 2'd1)) begin
            n_fail++; $display("FAIL slot1: got reg_en=%h imm=%h pc=%0d, want 0004 ffff 1", reg_en, imm, pc);
        end
        tick();
        n_checks++;
        if (!(reg_en === 16'h0 && pc === 2'd2 && busy === 1 && done === 0)) begin
            n_fail++; $display("FAIL halt_slot: got reg_en=%h pc=%0d busy=%b done=%b, want 0000 2 1 0", reg_en, pc, busy, done);
        end
        tick();
        n_checks++;
        if (!(done === 1 && busy === 0 && pc === 2'd2 && {reg_en, imm, b_sel} === '0)) begin
            n_fail++; $display("FAIL done_after_halt: got done=%b busy=%b pc=%0d reg_en=%h, want 1 0 2 0000", done, busy, pc, reg_en);
        end
    endtask

    task automatic load_four();
        for (int k = 0; k < 4; k++) begin
            load(k, mw(0, 1, 4'(k + 4), 4'(k), 4'(k + 1), 16'h0100 + 16'(k), 0, 4'(k), 1, 0));
        end
    endtask

    task automatic test_hold();
        load_four();
        step_en = 1; loop_mode = 0; start = 1;
        tick();
        start = 0;
        tick(); tick();
        step_en = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (!(pc === 2'd1 && reg_en === 16'h0020 && imm === 16'h0101 && opcode === 4'd1 && reg_b === 4'd2)) begin
                n_fail++; $display("FAIL hold_%0d: got pc=%0d reg_en=%h imm=%h opcode=%0d, want 1 0020 0101 1", i, pc, reg_en, imm, opcode);
            end
        end
        step_en = 1;
        tick();
        n_checks++;
        if (!(pc === 2'd2 && reg_en === 16'h0040 && imm === 16'h0102)) begin
            n_fail++; $display("FAIL resume: got pc=%0d reg_en=%h imm=%h, want 2 0040 0102", pc, reg_en, imm);
        end
        tick(); tick();
        n_checks++;
        if (!(done === 1 && busy === 0)) begin
            n_fail++; $display("FAIL end_no_loop: got done=%b busy=%b, want 1 0", done, busy);
        end
    endtask

    task automatic test_loop();
        logic [1:0] exp_pc [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        loop_mode = 1; step_en = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (!(pc === exp_pc[i] && reg_en === (16'h0010 << exp_pc[i]) && busy === 1)) begin
                n_fail++; $display("FAIL loop_%0d: got pc=%0d reg_en=%h, want %0d %h", i, pc, reg_en, exp_pc[i], 16'h0010 << exp_pc[i]);
            end
        end
        loop_mode = 0;
        tick(); tick();
        n_checks++;
        if (!(pc === 2'd3 && busy === 1)) begin
            n_fail++; $display("FAIL loop_last: got pc=%0d busy=%b, want 3 1", pc, busy);
        end
        tick();
        n_checks++;
        if (!(done === 1 && busy === 0)) begin
            n_fail++; $display("FAIL loop_exit: got done=%b busy=%b, want 1 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        step_en = 1; start = 1;
        tick();
        start = 0;
        tick(); tick(); tick();
        n_checks++;
        if (pc !== 2'd2) begin
            n_fail++; $display("FAIL mid_pc: got pc=%0d, want 2", pc);
        end
        rst = 1;
        #1;
        n_checks++;
        if (!(reg_en === 16'h0 && busy === 0 && pc === 2'd0 && imm === 16'h0)) begin
            n_fail++; $display("FAIL mid_reset: got reg_en=%h busy=%b pc=%0d imm=%h, want 0000 0 0 0000", reg_en, busy, pc, imm);
        end
        tick();
        rst = 0;
        start = 1;
        tick();
        start = 0;
        tick();
        n_checks++;
        if (!(pc === 2'd0 && reg_en === 16'h0010 && imm === 16'h0100)) begin
            n_fail++; $display("FAIL restart: got pc=%0d reg_en=%h imm=%h, want 0 0010 0100", pc, reg_en, imm);
        end
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_busy_ignore();
        step_en = 1; start = 1;
        tick();
        start = 0;
        tick(); tick();
        prog_addr = 2; prog_data = mw(0, 1, 15, 0, 0, 16'hdead, 0, 0, 0, 0);
        prog_we = 1; start = 1;
        tick();
        prog_we = 0; start = 0;
        n_checks++;
        if (!(pc === 2'd2 && reg_en === 16'h0040 && imm === 16'h0102 && busy === 1)) begin
            n_fail++; $display("FAIL busy_run: got pc=%0d reg_en=%h imm=%h busy=%b, want 2 0040 0102 1", pc, reg_en, imm, busy);
        end
        tick(); tick();
        start = 1;
        tick();
        start = 0;
        tick(); tick(); tick();
        n_checks++;
        if (!(pc === 2'd2 && reg_en === 16'h0040 && imm === 16'h0102)) begin
            n_fail++; $display("FAIL busy_mem: got pc=%0d reg_en=%h imm=%h, want 2 0040 0102", pc, reg_en, imm);
        end
        tick(); tick();
    endtask

`ifdef DATAPATH_SEQ_CHECK_EN
    task automatic test_check();
        load(0, mw(0, 0, 0, 0, 0, 16'h0011, 1, 0, 0, 1));
        load(1, mw(0, 0, 0, 0, 0, 16'h0011, 1, 0, 0, 1));
        load(2, mw(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
        step_en = 1; start = 1;
        tick();
        start = 0;
        tick();
        result = 16'h0010;
        tick();
        n_checks++;
        if (!(mismatch === 1 && err_count === 8'd1)) begin
            n_fail++; $display("FAIL chk_bad: got mismatch=%b err_count=%0d, want 1 1", mismatch, err_count);
        end
        result = 16'h0011;
        tick();
        n_checks++;
        if (!(mismatch === 0 && err_count === 8'd1)) begin
            n_fail++; $display("FAIL chk_good: got mismatch=%b err_count=%0d, want 0 1", mismatch, err_count);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_loop();
        test_reset_mid();
        test_busy_ignore();
`ifdef DATAPATH_SEQ_CHECK_EN
        test_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
